mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage data-memory access controller.
- Sits directly downstream of the EX/MEM segment registers. It consumes the registered store data (reg2_MEM), the ALU address, and the load/store control.
- It drives a req/ack data-memory port and formats the store data and byte enables. It sign- or zero-extends load data for MEM/WB.
- It raises a stall to the hazard unit while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, wait cycles in BUSY before abort. Used only with MEM_TIMEOUT_EN.
- CNT_W, 8, width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- mem_read_MEM  in  1  load in MEM stage.
- mem_write_MEM  in  1  store in MEM stage.
- funct3_MEM  in  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr_MEM  in  32  byte address from ALU.
- reg2_MEM  in  32  store data from EX/MEM segment register.
- flushM  in  1  MEM-stage flush; suppresses issue.
- dmem_req  out  1  memory request; held high until dmem_ack.
- dmem_we  out  1  write enable; valid with dmem_req.
- dmem_addr  out  32  word address: {addr[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  memory completion; single-cycle pulse.
- dmem_rdata  in  32  read word; valid when dmem_ack=1.
- load_data  out  32  extended load result to MEM/WB.
- stall_mem  out  1  combinational stall to hazard unit.
- access_err  out  1  one-cycle pulse: misaligned or illegal funct3.
- bus_err  out  1  one-cycle pulse on timeout (macro only; else tied 0).

Behaviour:
- Access valid, acc_v = (mem_read_MEM | mem_write_MEM) & ~flushM & legal & aligned.
- Alignment rules:
  - h/hu require addr[0]=0.
  - w requires addr[1:0]=0.
  - Legal store funct3: 000/001/010 only.
  - Legal load funct3: 000/001/010/100/101 only.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if acc_v, latch addr/be/wdata/we/funct3/byte offset, then go to BUSY. Otherwise stay in IDLE.
  - BUSY: dmem_req=1 with latched fields. On dmem_ack, capture extended read data into load_q and go to DONE.
  - DONE: go to IDLE unconditionally. Never reissue in DONE, because the MEM instruction is still present.
- stall_mem = (IDLE & acc_v) | BUSY. It is low in DONE, so the pipeline advances at the end of DONE.
- Minimum latency is 3 cycles (IDLE, BUSY with same-cycle ack, DONE).
- Store formatting:
  - sb: wdata = {4{b}}, be = 4'b0001 << addr[1:0].
  - sh: wdata = {2{h}}, be = 0011 if addr[1]=0, else 1100.
  - sw: wdata = reg2, be = 1111.
  - Loads: be = 1111, we = 0.
- Load extension:
  - Select the byte/half by the latched offset.
  - b/h: sign-extend. bu/hu: zero-extend. w: pass through.
  - Stores leave load_q unchanged.
- load_data = load_q. It holds its value until the next load completes.
- Access errors:
  - A misaligned or illegal access with mem_read|mem_write and ~flushM pulses access_err for one cycle in IDLE.
  - No request is issued, no stall, and load_q is cleared to 0.
- flushM is sampled only in IDLE. While BUSY, flushM is ignored and the transaction always completes.
- dmem_ack outside BUSY is ignored.
- Reset (async, any state):
  - state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0.
  - load_q=0, access_err=0, bus_err=0, timeout counter=0.
  - Reset during BUSY drops dmem_req immediately, and any later ack is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A CNT_W-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - At TIMEOUT_CYCLES: drop dmem_req, pulse bus_err for one cycle, set load_q=0, go to DONE.
  - An ack in the same cycle as the timeout wins: normal completion, no bus_err.
- Undefined: no counter; BUSY waits indefinitely and bus_err is constant 0.

Test Plan:
- lw addr=0x100, ack after 2 BUSY cycles, rdata=0xDEADBEEF → dmem_addr=0x100, be=1111; stall_mem high for 3 cycles; load_data=0xDEADBEEF in DONE.
- sb addr=0x203, reg2=0x123456A5 → wdata=0xA5A5A5A5, be=1000, we=1; single-cycle ack gives a 3-cycle total with stall low in DONE.
- lb addr=0x2, rdata=0x00800000 → load_data=0xFFFFFF80. Repeat as lbu → 0x00000080. lh addr=0x2, rdata=0x8001xxxx → 0xFFFF8001.
- lw addr=0x102 → access_err one-cycle pulse, dmem_req stays 0, stall_mem 0, load_data=0. mem_write with funct3=100 → access_err.
- rst asserted mid-BUSY → dmem_req falls without clk edge. A late ack gives no state change and load_data=0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → bus_err pulses after 4 BUSY cycles, then DONE, stall released, load_data=0. With ack on the 4th cycle → no bus_err.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Brief    : MEM-stage data-memory access controller. Issues req/ack memory
//             transactions, formats store lanes/byte enables, extends load
//             data for MEM/WB and stalls the pipeline while an access is
//             outstanding.
//  Options  : MEM_TIMEOUT_EN - abort a BUSY access after TIMEOUT_CYCLES
//             cycles without ack and pulse bus_err.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_MEM,
  input  logic        mem_write_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] addr_MEM,
  input  logic [31:0] reg2_MEM,
  input  logic        flushM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        stall_mem,
  output logic        access_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_load_q;
  logic        r_access_err;

  logic        w_acc_req;
  logic        w_legal;
  logic        w_aligned;
  logic        w_acc_v;
  logic        w_acc_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

`ifdef MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
`else
  // Timeout parameters only matter when the timeout option is built in.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0) ^ (CNT_W > 0);
`endif

  assign w_acc_req = (mem_read_MEM | mem_write_MEM) & ~flushM;
  assign w_acc_v   = w_acc_req & w_legal & w_aligned;
  assign w_acc_err = w_acc_req & ~(w_legal & w_aligned);

  // Legal funct3 encodings: stores have no unsigned variants
  always_comb begin
    w_legal = 1'b0;
    if (mem_write_MEM) begin
      case (funct3_MEM)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        default:                w_legal = 1'b0;
      endcase
    end else begin
      case (funct3_MEM)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                w_legal = 1'b0;
      endcase
    end
  end

  // Natural alignment by access size (funct3[1:0] encodes the size)
  always_comb begin
    w_aligned = 1'b1;
    case (funct3_MEM[1:0])
      2'b01:   w_aligned = ~addr_MEM[0];
      2'b10:   w_aligned = (addr_MEM[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  // Store lane replication and byte enables; loads always fetch the full word
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = reg2_MEM;
    if (mem_write_MEM) begin
      case (funct3_MEM[1:0])
        2'b00: begin
          w_be    = 4'b0001 << addr_MEM[1:0];
          w_wdata = {4{reg2_MEM[7:0]}};
        end
        2'b01: begin
          w_be    = addr_MEM[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{reg2_MEM[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = reg2_MEM;
        end
      endcase
    end
  end

  // Select the addressed byte/half from the returned word and extend it
  always_comb begin
    w_ext = dmem_rdata;
    case (r_f3)
      3'b000:  w_ext = {{24{dmem_rdata[{r_off, 3'b111}]}}, dmem_rdata[{r_off, 3'b000} +: 8]};
      3'b100:  w_ext = {24'h000000, dmem_rdata[{r_off, 3'b000} +: 8]};
      3'b001:  w_ext = r_off[1] ? {{16{dmem_rdata[31]}}, dmem_rdata[31:16]}
                                : {{16{dmem_rdata[15]}}, dmem_rdata[15:0]};
      3'b101:  w_ext = r_off[1] ? {16'h0000, dmem_rdata[31:16]}
                                : {16'h0000, dmem_rdata[15:0]};
      default: w_ext = dmem_rdata;
    endcase
  end

  // Access FSM: IDLE issues, BUSY waits for ack, DONE lets the pipeline advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'h0;
      r_be         <= 4'h0;
      r_wdata      <= 32'h0;
      r_f3         <= 3'b000;
      r_off        <= 2'b00;
      r_load_q     <= 32'h0;
      r_access_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt        <= '0;
      r_bus_err    <= 1'b0;
`endif
    end else begin
      r_access_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_bus_err    <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_acc_v) begin
            r_req   <= 1'b1;
            r_we    <= mem_write_MEM;
            r_addr  <= {addr_MEM[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_f3    <= funct3_MEM;
            r_off   <= addr_MEM[1:0];
`ifdef MEM_TIMEOUT_EN
            r_cnt   <= '0;
`endif
            r_state <= ST_BUSY;
          end else if (w_acc_err) begin
            r_access_err <= 1'b1;
            r_load_q     <= 32'h0;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            r_req <= 1'b0;
            if (!r_we) begin
              r_load_q <= w_ext;
            end
            r_state <= ST_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_cnt == c_tmo_last) begin
            r_req     <= 1'b0;
            r_bus_err <= 1'b1;
            r_load_q  <= 32'h0;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall_mem  = ((r_state == ST_IDLE) & w_acc_v) | (r_state == ST_BUSY);
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;
  assign load_data  = r_load_q;
  assign access_err = r_access_err;
`ifdef MEM_TIMEOUT_EN
  assign bus_err    = r_bus_err;
`else
  assign bus_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Brief    : Directed self-checking bench for mem_access_ctrl with a
//             transaction-level expectation model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_MEM, mem_write_MEM, flushM;
  logic [2:0]  funct3_MEM;
  logic [31:0] addr_MEM, reg2_MEM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
  logic [3:0]  dmem_be;
  logic        stall_mem, access_err, bus_err;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_read_MEM(mem_read_MEM), .mem_write_MEM(mem_write_MEM),
    .funct3_MEM(funct3_MEM), .addr_MEM(addr_MEM), .reg2_MEM(reg2_MEM),
    .flushM(flushM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .load_data(load_data), .stall_mem(stall_mem),
    .access_err(access_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Per-cycle expectations driven by the transaction tasks
  logic        chk_en = 1'b0;
  logic        e_req = 1'b0, e_stall = 1'b0, e_we = 1'b0, e_aerr = 1'b0, e_berr = 1'b0;
  logic [3:0]  e_be = 4'h0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, m_load = 32'h0;

  // Observation counters / last-seen bus values for literal checks
  int          n_stall = 0, n_aerr = 0, n_berr = 0;
  logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_be = 4'h0;
  logic        last_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_legal(input logic wr, input logic [2:0] f3);
    if (wr) return f3 inside {3'b000, 3'b001, 3'b010};
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  function automatic logic model_aligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % acc_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = acc_size(f3);
    if (!wr) return 4'hF;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] r2);
    int sz;
    sz = acc_size(f3);
    if (sz == 1) return (r2 & 32'hFF) * 32'h01010101;
    if (sz == 2) return (r2 & 32'hFFFF) * 32'h00010001;
    return r2;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int          sz;
    int unsigned v, span;
    sz = acc_size(f3);
    if (sz == 4) return rd;
    span = 32'd1 << (8 * sz);
    v = (rd >> (8 * (a % 4))) % span;
    if (!f3[2] && v >= span / 2) v = v - span;
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_mem", {31'b0, stall_mem}, {31'b0, e_stall});
      check("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
      check("load_data", load_data, m_load);
      check("access_err", {31'b0, access_err}, {31'b0, e_aerr});
      check("bus_err", {31'b0, bus_err}, {31'b0, e_berr});
      if (e_req) begin
        check("dmem_addr", dmem_addr, e_addr);
        check("dmem_be", {28'b0, dmem_be}, {28'b0, e_be});
        check("dmem_we", {31'b0, dmem_we}, {31'b0, e_we});
        if (e_we) check("dmem_wdata", dmem_wdata, e_wdata);
      end
      if (stall_mem) n_stall++;
      if (access_err) n_aerr++;
      if (bus_err) n_berr++;
      if (dmem_req) begin
        last_addr  = dmem_addr;
        last_be    = dmem_be;
        last_we    = dmem_we;
        last_wdata = dmem_wdata;
      end
    end
  end

  // ---------------- transaction driver ----------------
  // ack_at: BUSY cycle (1-based) that carries the ack; 0 = never ack.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] r2,
                        input int ack_at, input logic [31:0] rdv, input logic fl);
    logic ok, err, acked, timed;
    ok  = (rd | wr) && !fl && model_legal(wr, f3) && model_aligned(f3, a);
    err = (rd | wr) && !fl && !ok;
    mem_read_MEM = rd; mem_write_MEM = wr; funct3_MEM = f3;
    addr_MEM = a; reg2_MEM = r2; flushM = fl; dmem_ack = 1'b0;
    e_stall = ok; e_req = 1'b0; e_aerr = 1'b0; e_berr = 1'b0;
    @(posedge clk); #1;
    if (!ok) begin
      mem_read_MEM = 1'b0; mem_write_MEM = 1'b0; flushM = 1'b0;
      e_stall = 1'b0;
      e_aerr  = err;
      if (err) m_load = 32'h0;
      @(posedge clk); #1;
      e_aerr = 1'b0;
      return;
    end
    e_req = 1'b1; e_stall = 1'b1; e_we = wr;
    e_addr = a & 32'hFFFF_FFFC;
    e_be = model_be(wr, f3, a);
    e_wdata = model_wdata(f3, r2);
    acked = 1'b0; timed = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      dmem_ack = (ack_at == k);
      dmem_rdata = rdv;
      acked = dmem_ack;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
      if (acked) break;
      if (TMO_EN && k == TMO) begin
        timed = 1'b1;
        break;
      end
    end
    if (!acked && !timed) begin
      n_chk++; n_err++;
      $display("FAIL busy_bound: access never completed, got no ack expected completion");
    end
    // DONE cycle: instruction still present, no stall, no reissue
    e_req = 1'b0; e_stall = 1'b0;
    if (acked && !wr) m_load = model_load(f3, a, rdv);
    if (timed) begin
      m_load = 32'h0;
      e_berr = 1'b1;
    end
    @(posedge clk); #1;
    e_berr = 1'b0;
    mem_read_MEM = 1'b0; mem_write_MEM = 1'b0; flushM = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0, b0;
    rst = 1'b1;
    mem_read_MEM = 1'b0; mem_write_MEM = 1'b0; flushM = 1'b0;
    funct3_MEM = 3'b000; addr_MEM = 32'h0; reg2_MEM = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #2;
    check("rst_req", {31'b0, dmem_req}, 32'h0);
    check("rst_we", {31'b0, dmem_we}, 32'h0);
    check("rst_be", {28'b0, dmem_be}, 32'h0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_load", load_data, 32'h0);
    check("rst_aerr", {31'b0, access_err}, 32'h0);
    check("rst_berr", {31'b0, bus_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    idle_cycles(2);

    // lw 0x100, ack on second BUSY cycle
    s0 = n_stall;
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0);
    check("lw_load_lit", load_data, 32'hDEADBEEF);
    check("lw_addr_lit", last_addr, 32'h100);
    check("lw_be_lit", {28'b0, last_be}, 32'hF);
    check("lw_stall_cycles", n_stall - s0, 3);

    // sb 0x203, single-cycle ack
    s0 = n_stall;
    access(1'b0, 1'b1, 3'b000, 32'h203, 32'h123456A5, 1, 32'h0, 1'b0);
    check("sb_wdata_lit", last_wdata, 32'hA5A5A5A5);
    check("sb_be_lit", {28'b0, last_be}, 32'h8);
    check("sb_we_lit", {31'b0, last_we}, 32'h1);
    check("sb_addr_lit", last_addr, 32'h200);
    check("sb_stall_cycles", n_stall - s0, 2);
    check("sb_keeps_load", load_data, 32'hDEADBEEF);

    // sign/zero extension
    access(1'b1, 1'b0, 3'b000, 32'h2, 32'h0, 1, 32'h00800000, 1'b0);
    check("lb_lit", load_data, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'b100, 32'h2, 32'h0, 1, 32'h00800000, 1'b0);
    check("lbu_lit", load_data, 32'h00000080);
    access(1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 3, 32'h80011234, 1'b0);
    check("lh_lit", load_data, 32'hFFFF8001);
    access(1'b1, 1'b0, 3'b101, 32'h4, 32'h0, 1, 32'h1234F00D, 1'b0);
    check("lhu_lit", load_data, 32'h0000F00D);
    access(1'b1, 1'b0, 3'b000, 32'h1, 32'h0, 2, 32'h00007F00, 1'b0);
    access(1'b1, 1'b0, 3'b000, 32'h3, 32'h0, 1, 32'h9C000000, 1'b0);
    access(0, 1, 3'b001, 32'h6, 32'hCAFEBEEF, 1, 32'h0, 1'b0);
    access(0, 1, 3'b001, 32'h8, 32'h00001234, 2, 32'h0, 1'b0);
    access(0, 1, 3'b010, 32'h10, 32'h0BADF00D, 3, 32'h0, 1'b0);
    access(0, 1, 3'b000, 32'h11, 32'h000000C3, 1, 32'h0, 1'b0);

    // ack outside BUSY is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    idle_cycles(1);
    dmem_ack = 1'b0;
    idle_cycles(1);

    // flushed access: nothing happens
    access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1, 32'h0, 1'b1);

    // access errors
    a0 = n_aerr;
    access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h0, 1'b0);
    check("lw_mis_aerr_pulses", n_aerr - a0, 1);
    check("lw_mis_load_lit", load_data, 32'h0);
    access(1'b0, 1'b1, 3'b100, 32'h20, 32'h0, 1, 32'h0, 1'b0);
    check("sbu_illegal_aerr", n_aerr - a0, 2);
    access(1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 1, 32'h0, 1'b0);
    access(1'b0, 1'b1, 3'b001, 32'h21, 32'h0, 1, 32'h0, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h33, 32'h0, 1, 32'h0, 1'b1);

    // reset mid-BUSY
    access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 1, 32'h76543210, 1'b0);
    chk_en = 1'b0;
    mem_read_MEM = 1'b1; funct3_MEM = 3'b010; addr_MEM = 32'h400;
    @(posedge clk); #2;
    check("rst_busy_req_high", {31'b0, dmem_req}, 32'h1);
    rst = 1'b1; mem_read_MEM = 1'b0;
    #1;
    check("rst_async_req_drop", {31'b0, dmem_req}, 32'h0);
    check("rst_async_load", load_data, 32'h0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFEEDFACE;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("late_ack_req", {31'b0, dmem_req}, 32'h0);
    check("late_ack_stall", {31'b0, stall_mem}, 32'h0);
    check("late_ack_load", load_data, 32'h0);
    m_load = 32'h0; e_req = 1'b0; e_stall = 1'b0; e_aerr = 1'b0; e_berr = 1'b0;
    chk_en = 1'b1;
    idle_cycles(1);

    // timeout behaviour
    if (TMO_EN) begin
      access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1, 32'h13572468, 1'b0);
      b0 = n_berr;
      s0 = n_stall;
      access(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 0, 32'h0, 1'b0);
      check("tmo_berr_pulses", n_berr - b0, 1);
      check("tmo_stall_cycles", n_stall - s0, 5);
      check("tmo_load_lit", load_data, 32'h0);
      access(1'b1, 1'b0, 3'b010, 32'h308, 32'h0, TMO, 32'h2468ACE0, 1'b0);
      check("tmo_ack_wins_berr", n_berr - b0, 1);
      check("tmo_ack_wins_load", load_data, 32'h2468ACE0);
    end

    idle_cycles(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
